// File: rtl/deparser_pkg.sv
// Shared encodings, bank geometry defaults and byte-lane helpers for the header bank writer.
// Latency: none (package of constants, types and pure functions).
// Backpressure: not applicable.
package deparser_pkg;

    localparam int DEPTH_DEF  = 128;
    localparam int ADDR_W_DEF = 7;

    localparam logic [1:0] VAL_TYPE_NONE = 2'b00;
    localparam logic [1:0] VAL_TYPE_2B   = 2'b01;
    localparam logic [1:0] VAL_TYPE_4B   = 2'b10;
    localparam logic [1:0] VAL_TYPE_8B   = 2'b11;

    // One drained beat as held in the output skid FIFO.
    typedef struct packed {
        logic [63:0] dat;
        logic        last;
    } beat_t;

    // Each bank carries half of the write width, so an 8B write fills all four lanes.
    function automatic logic [3:0] type_to_be(input logic [1:0] val_type);
        logic [3:0] be;
        case (val_type)
            VAL_TYPE_8B:   be = 4'hF;
            VAL_TYPE_4B:   be = 4'h3;
            VAL_TYPE_2B:   be = 4'h1;
            VAL_TYPE_NONE: be = 4'h0;
            default:       be = 4'h0;
        endcase
        return be;
    endfunction

    // Rebuild wire byte order: byte 2k from the even bank lane k, byte 2k+1 from the odd bank.
    function automatic logic [63:0] interleave(input logic [31:0] even_w, input logic [31:0] odd_w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[16*k +: 8]     = even_w[8*k +: 8];
            r[16*k + 8 +: 8] = odd_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/deparser_bank_writer_if.sv
// Bundles the sub-deparser write port, drain control and 64-bit output stream.
// Latency: none (wiring only).
// Backpressure: in_ready gates writes, m_tready stalls the output stream.
interface deparser_bank_writer_if;
    logic        val_in_valid;
    logic [31:0] val_in1;
    logic [31:0] val_in2;
    logic [1:0]  val_in_type;
    logic [7:0]  val_in_offset1;
    logic [7:0]  val_in_offset2;
    logic        in_ready;
    logic        pkt_done;
    logic [7:0]  hdr_len;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        addr_err;

    modport master (
        output val_in_valid, val_in1, val_in2, val_in_type, val_in_offset1, val_in_offset2,
        output pkt_done, hdr_len, m_tready,
        input  in_ready, m_tdata, m_tvalid, m_tlast, addr_err
    );

    modport slave (
        input  val_in_valid, val_in1, val_in2, val_in_type, val_in_offset1, val_in_offset2,
        input  pkt_done, hdr_len, m_tready,
        output in_ready, m_tdata, m_tvalid, m_tlast, addr_err
    );
endinterface

// File: rtl/deparser_bank_ram.sv
// DEPTH x 32 header bank with per-byte write enable.
// Latency: read data one cycle after the address; a write is visible to a read issued next cycle.
// Backpressure: none, accepts a read and a write every cycle.
module deparser_bank_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write and registered read; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/deparser_bank_writer.sv
// Collects split even/odd header writes into two banks, then drains them as 64-bit beats and zeroes them.
// Latency: pkt_done -> first m_tvalid three cycles later; one beat per cycle while m_tready is high.
// Backpressure: 2-entry skid FIFO absorbs m_tready stalls; reads issue only when the FIFO has room.
module deparser_bank_writer
    import deparser_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   aresetn,
    deparser_bank_writer_if.slave  bus_io
);

    localparam int          LEN_W   = ADDR_W + 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              rd_vld_q, rd_last_q;
    logic              clr_vld_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              addr_err_q;
    beat_t             ent0_q, ent1_q;
    logic [1:0]        cnt_q;

    logic              in_ready;
    logic              wr_req, ok1, ok2;
    logic [3:0]        be;
    logic [3:0]        we_e, we_o;
    logic [ADDR_W-1:0] wa_e, wa_o;
    logic [31:0]       wd_e, wd_o;
    logic [31:0]       rdata_e, rdata_o;
    logic              push, pop, issue;
    logic [1:0]        cnt_n;
    beat_t             beat_in;

    assign in_ready = (state_q == ST_COLLECT);
    assign wr_req   = in_ready && bus_io.val_in_valid && (bus_io.val_in_type != VAL_TYPE_NONE);
    assign ok1      = 32'(bus_io.val_in_offset1) < DEPTH_U;
    assign ok2      = 32'(bus_io.val_in_offset2) < DEPTH_U;
    assign be       = type_to_be(bus_io.val_in_type);

    assign push    = rd_vld_q;
    assign pop     = (cnt_q != 2'd0) && bus_io.m_tready;
    assign cnt_n   = cnt_q + 2'(push) - 2'(pop);
    // Conservative room check: the read issued now lands next cycle whether or not that cycle pops.
    assign issue   = (state_q == ST_DRAIN) && (rd_ptr_q < len_q) && (cnt_n < 2'd2);
    assign beat_in = '{dat: interleave(rdata_e, rdata_o), last: rd_last_q};

    // Single write port per bank: sweep clears, then post-read clears, then sub-deparser writes.
    always_comb begin
        we_e = 4'h0;
        we_o = 4'h0;
        wa_e = bus_io.val_in_offset1[ADDR_W-1:0];
        wa_o = bus_io.val_in_offset2[ADDR_W-1:0];
        wd_e = bus_io.val_in1;
        wd_o = bus_io.val_in2;
        if (state_q == ST_CLEAR) begin
            we_e = 4'hF;
            we_o = 4'hF;
            wa_e = sweep_q;
            wa_o = sweep_q;
            wd_e = '0;
            wd_o = '0;
        end else if (clr_vld_q) begin
            we_e = 4'hF;
            we_o = 4'hF;
            wa_e = clr_addr_q;
            wa_o = clr_addr_q;
            wd_e = '0;
            wd_o = '0;
        end else if (wr_req) begin
            we_e = ok1 ? be : 4'h0;
            we_o = ok2 ? be : 4'h0;
        end
    end

    deparser_bank_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank_e (
        .clk     (clk),
        .we_i    (we_e),
        .waddr_i (wa_e),
        .wdata_i (wd_e),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata_e)
    );

    deparser_bank_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank_o (
        .clk     (clk),
        .we_i    (we_o),
        .waddr_i (wa_o),
        .wdata_i (wd_o),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata_o)
    );

    // Next-state: sweep, wait for pkt_done, then drain until the tlast beat is accepted.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_q + ADDR_W'(1);
                if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                    sweep_d = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus_io.pkt_done) begin
                    len_d    = (32'(bus_io.hdr_len) > DEPTH_U) ? LEN_W'(DEPTH) : LEN_W'(bus_io.hdr_len);
                    rd_ptr_d = '0;
                    if (bus_io.hdr_len != 8'd0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + LEN_W'(1);
                end
                if (pop && ent0_q.last) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Control state, read pipeline tags and the sticky dropped-offset flag.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            clr_vld_q  <= 1'b0;
            clr_addr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_vld_q   <= issue;
            rd_last_q  <= (rd_ptr_q == len_q - LEN_W'(1));
            clr_vld_q  <= issue;
            clr_addr_q <= rd_ptr_q[ADDR_W-1:0];
            addr_err_q <= addr_err_q | (wr_req & (~ok1 | ~ok2));
        end
    end

    // Two-entry skid FIFO; the head only moves on a pop or when filling an empty FIFO.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q <= cnt_n;
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= beat_in;
                    else               ent1_q <= beat_in;
                end
                2'b01: ent0_q <= ent1_q;
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= beat_in;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= beat_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_io.in_ready = in_ready;
    assign bus_io.m_tvalid = (cnt_q != 2'd0);
    assign bus_io.m_tdata  = ent0_q.dat;
    assign bus_io.m_tlast  = ent0_q.last && (cnt_q != 2'd0);
    assign bus_io.addr_err = addr_err_q;

endmodule
